lcd_bus_driver: RTL and testbench

//  Byte-level HD44780 write engine for the 16x2 character LCD. Sits directly

---
 rtl/lcd_bus_driver_pkg.sv | 39 +++
 rtl/lcd_bus_driver.sv | 138 +++++++++++++
 tb/tb_lcd_bus_driver.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_driver_pkg.sv
// Shared definitions for the HD44780 byte write engine: FSM states,
// special command bytes, default bus timing and small helper functions.
package lcd_bus_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    localparam int DEF_SETUP_CYC    = 4;
    localparam int DEF_EN_HIGH_CYC  = 16;
    localparam int DEF_HOLD_CYC     = 4;
    localparam int DEF_CMD_WAIT_CYC = 2000;
    localparam int DEF_CLR_WAIT_CYC = 82000;

    // Largest of the five timing values, used to size the shared counter.
    function automatic int max_cyc(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

    // Clear display and return home are the slow instructions on the controller.
    function automatic logic needs_long_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && ((data == LCD_CMD_CLEAR) || (data == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_driver.sv
// Byte-level HD44780 write engine. Accepts one command/data byte per
// handshake and generates the RS/RW/EN/DATA bus cycle followed by the
// controller execution wait. All outputs come straight from flops.
module lcd_bus_driver
    import lcd_bus_driver_pkg::*;
#(
    parameter int SETUP_CYC    = DEF_SETUP_CYC,
    parameter int EN_HIGH_CYC  = DEF_EN_HIGH_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int CMD_WAIT_CYC = DEF_CMD_WAIT_CYC,
    parameter int CLR_WAIT_CYC = DEF_CLR_WAIT_CYC
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iSTART,
    input  logic       iRS,
    input  logic [7:0] iDATA,
    output logic       oBUSY,
    output logic       oDONE,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int MAX_CYC = max_cyc(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC,
                                     CMD_WAIT_CYC, CLR_WAIT_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Terminal counts: each phase lasts exactly N cycles, counting 0..N-1.
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             long_wait_q, long_wait_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             en_q, en_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] wait_last;

    assign wait_last = long_wait_q ? CLR_LAST : CMD_LAST;

    // Next-state logic: walk setup, enable, hold and execution wait, then pulse done.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        long_wait_d = long_wait_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        en_d        = en_q;
        rs_d        = rs_q;
        data_d      = data_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (iSTART) begin
                    rs_d        = iRS;
                    data_d      = iDATA;
                    long_wait_d = needs_long_wait(iRS, iDATA);
                    busy_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = ST_EN_HI;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write in progress without a done pulse.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            long_wait_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_wait_q <= long_wait_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_q        <= en_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
        end
    end

    assign oBUSY    = busy_q;
    assign oDONE    = done_q;
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_DATA = data_q;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver: the driver pushes the expected bus
// cycle for every accepted write, the monitor checks it when oDONE appears.
module tb_lcd_bus_driver;

    localparam int SETUP = 4;
    localparam int ENH   = 16;
    localparam int HOLD  = 4;
    localparam int CMDW  = 2000;
    localparam int CLRW  = 10000;

    logic       iCLK   = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iSTART = 1'b0;
    logic       iRS    = 1'b0;
    logic [7:0] iDATA  = 8'h00;
    logic       oBUSY;
    logic       oDONE;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         acc;
        int         done_at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks       = 0;
    int   passes       = 0;
    int   cyc          = 0;
    int   en_pulses    = 0;
    int   pulses_since = 0;
    int   done_count   = 0;
    int   issued       = 0;
    int   rise_cyc     = 0;
    int   fall_cyc     = 0;
    logic prev_en      = 1'b0;
    int   base_done;
    int   base_pulses;

    lcd_bus_driver #(
        .SETUP_CYC   (SETUP),
        .EN_HIGH_CYC (ENH),
        .HOLD_CYC    (HOLD),
        .CMD_WAIT_CYC(CMDW),
        .CLR_WAIT_CYC(CLRW)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iSTART  (iSTART),
        .iRS     (iRS),
        .iDATA   (iDATA),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .LCD_DATA(LCD_DATA),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN),
        .LCD_RS  (LCD_RS)
    );

    // 50 MHz clock, 20 ns period.
    always #10 iCLK = ~iCLK;

    // Edge counter: after posedge N, cyc equals N.
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic int expWait(input logic rs, input logic [7:0] data);
        if (rs == 1'b0 && (data == 8'h01 || data == 8'h02)) return CLRW;
        return CMDW;
    endfunction

    // Wait for the engine to be free, present a byte and record what it must produce.
    task automatic applyStimulus(input logic rs, input logic [7:0] data, input bit hold);
        exp_t e;
        int   budget = 0;
        do begin
            @(negedge iCLK);
            budget++;
        end while (oBUSY && budget < 30000);
        if (oBUSY) begin
            checks++;
            $display("[TB] FAIL busy_timeout: oBUSY=1 after %0d cycles, expected 0", budget);
            return;
        end
        iRS    = rs;
        iDATA  = data;
        iSTART = 1'b1;
        e.rs      = rs;
        e.data    = data;
        e.acc     = cyc + 1;
        e.done_at = e.acc + SETUP + ENH + HOLD + expWait(rs, data);
        sb.push_back(e);
        issued++;
        if (!hold) begin
            @(negedge iCLK);
            iSTART = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int budget = 0;
        while (sb.size() > 0 && budget < 30000) begin
            @(negedge iCLK);
            budget++;
        end
        if (sb.size() > 0) begin
            checks++;
            $display("[TB] FAIL done_timeout: %0d writes outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic waitEnHigh();
        int budget = 0;
        while (!LCD_EN && budget < 100) begin
            @(negedge iCLK);
            budget++;
        end
        checkOutput("en_rise_wait", LCD_EN, 1);
    endtask

    // Monitor: track enable pulses and score each completed write against the queue.
    always @(negedge iCLK) begin
        if (LCD_EN && !prev_en) begin
            rise_cyc = cyc;
            en_pulses++;
            pulses_since++;
            if (sb.size() > 0) begin
                checkOutput("en_rise_data", LCD_DATA, sb[0].data);
                checkOutput("en_rise_rs", LCD_RS, sb[0].rs);
            end
        end
        if (!LCD_EN && prev_en) fall_cyc = cyc;
        prev_en = LCD_EN;
        if (oDONE) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL spurious_done: oDONE=1 with no write outstanding, expected 0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("done_cycle", cyc - mon_e.acc, mon_e.done_at - mon_e.acc);
                checkOutput("en_rise_offset", rise_cyc - mon_e.acc, SETUP);
                checkOutput("en_width", fall_cyc - rise_cyc, ENH);
                checkOutput("en_pulses_per_write", pulses_since, 1);
                checkOutput("done_data", LCD_DATA, mon_e.data);
                checkOutput("done_rs", LCD_RS, mon_e.rs);
                checkOutput("done_busy", oBUSY, 0);
                checkOutput("done_rw", LCD_RW, 0);
            end
            pulses_since = 0;
        end
    end

    // Hard stop in case the design never settles.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        checkOutput("rst_en", LCD_EN, 0);
        checkOutput("rst_rs", LCD_RS, 0);
        checkOutput("rst_data", LCD_DATA, 0);
        checkOutput("rst_busy", oBUSY, 0);
        checkOutput("rst_done", oDONE, 0);
        checkOutput("rst_rw", LCD_RW, 0);
        repeat (100) @(negedge iCLK);
        checkOutput("idle_no_en", en_pulses, 0);

        $display("[TB] data write 0x41");
        applyStimulus(1'b1, 8'h41, 1'b0);
        checkOutput("latch_data", LCD_DATA, 8'h41);
        checkOutput("latch_rs", LCD_RS, 1);
        checkOutput("latch_busy", oBUSY, 1);
        waitIdle();

        $display("[TB] clear / home and their data-byte twins");
        applyStimulus(1'b0, 8'h01, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 8'h01, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 8'h02, 1'b0);
        waitIdle();
        applyStimulus(1'b0, 8'h03, 1'b0);
        waitIdle();

        $display("[TB] back-to-back with iSTART held");
        base_pulses = en_pulses;
        applyStimulus(1'b0, 8'h30, 1'b1);
        applyStimulus(1'b0, 8'h38, 1'b0);
        waitIdle();
        repeat (50) @(negedge iCLK);
        checkOutput("b2b_pulses", en_pulses - base_pulses, 2);
        checkOutput("b2b_idle_busy", oBUSY, 0);

        $display("[TB] start during enable is ignored");
        base_done = done_count;
        applyStimulus(1'b1, 8'h55, 1'b0);
        waitEnHigh();
        iRS    = 1'b0;
        iDATA  = 8'h01;
        iSTART = 1'b1;
        @(negedge iCLK);
        iSTART = 1'b0;
        checkOutput("ignored_data", LCD_DATA, 8'h55);
        waitIdle();
        repeat (50) @(negedge iCLK);
        checkOutput("ignored_single_done", done_count - base_done, 1);
        checkOutput("ignored_hold_data", LCD_DATA, 8'h55);

        $display("[TB] reset during enable");
        applyStimulus(1'b0, 8'h0C, 1'b0);
        waitEnHigh();
        iRST_N = 1'b0;
        @(posedge iCLK);
        #1;
        checkOutput("abort_en", LCD_EN, 0);
        checkOutput("abort_busy", oBUSY, 0);
        checkOutput("abort_done", oDONE, 0);
        sb.delete();
        pulses_since = 0;
        base_done = done_count;
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2100) @(negedge iCLK);
        checkOutput("abort_no_done", done_count - base_done, 0);
        applyStimulus(1'b1, 8'h42, 1'b0);
        waitIdle();

        repeat (20) @(negedge iCLK);
        checkOutput("total_en_pulses", en_pulses, issued);
        checkOutput("total_done", done_count, issued - 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
